vc_biu_sync_fifo_lvl: RTL and testbench



---
 rtl/vc_biu_sync_fifo_lvl.sv | 179 +++++++++++++++++
 tb/tb_vc_biu_sync_fifo_lvl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vc_biu_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : vc_biu_sync_fifo_lvl
// Purpose  : Synchronous FIFO between the BIU write side and read side. Each
//            side has its own clock enable. The head word sits in a
//            registered output stage with active-low valid. The remaining
//            FIFO_DEPTH-1 words live in a circular store. The store depth
//            need not be a power of two.
//            Also provides an occupancy count, almost-full/almost-empty
//            levels, a synchronous flush, and sticky overflow/underflow flags.
// Ports    : core_clk, core_reset (sync, active-high)
//            wr_en/wr/wr_data          - push side
//            rd_en/rd                  - pop side, rd consumes rd_data
//            flush, err_clr            - control
//            rd_data, valid_n          - registered head word and valid
//            full, empty, count        - occupancy status
//            almost_full, almost_empty - level flags (registered)
//            overflow, underflow       - sticky error flags
// Revision : 1.0 - initial release
// ============================================================================
module vc_biu_sync_fifo_lvl #(
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int AF_LEVEL   = FIFO_DEPTH - 1,
  parameter int AE_LEVEL   = 1
) (
  input  logic                               core_clk,
  input  logic                               core_reset,
  input  logic                               wr_en,
  input  logic                               wr,
  input  logic [DATA_WIDTH-1:0]              wr_data,
  input  logic                               rd_en,
  input  logic                               rd,
  input  logic                               flush,
  input  logic                               err_clr,
  output logic [DATA_WIDTH-1:0]              rd_data,
  output logic                               valid_n,
  output logic                               full,
  output logic                               empty,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               almost_full,
  output logic                               almost_empty,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int SD     = FIFO_DEPTH - 1;             // store entries
  localparam int PTR_W  = (SD > 1) ? $clog2(SD) : 1;
  localparam int SCNT_W = $clog2(SD + 1);

  localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(SD - 1);
  localparam logic [SCNT_W-1:0] SCNT_FULL = SCNT_W'(SD);
  localparam logic [SCNT_W-1:0] SCNT_ONE  = SCNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  AF_THR    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0]  AE_THR    = CNT_W'(AE_LEVEL);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [SD];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [SCNT_W-1:0]     scnt_q, scnt_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  valid_n_q, valid_n_d;
  logic                  full_q, empty_q, af_q, ae_q;
  logic                  ovf_q, ovf_d, unf_q, unf_d;

  // Handshake decode
  logic push_acc, pop_acc, ld, store_ne, st_pop, bypass, st_push;

  // Wrap explicitly because the store depth may not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    push_acc = wr & wr_en & ~full_q & ~flush;
    pop_acc  = rd & rd_en & ~valid_n_q & ~flush;
    // The output stage reloads whenever it is empty or is being consumed.
    ld       = rd_en & (valid_n_q | pop_acc) & ~flush;
    store_ne = (scnt_q != '0);
    st_pop   = ld & store_ne;
    // An empty store lets an accepted push go straight to the output stage.
    bypass   = ld & ~store_ne & push_acc;
    st_push  = push_acc & ~bypass;
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    scnt_d    = scnt_q;
    count_d   = count_q;
    rd_data_d = rd_data_q;
    valid_n_d = valid_n_q;

    if (st_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (st_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);

    if (st_push && !st_pop)      scnt_d = scnt_q + SCNT_ONE;
    else if (st_pop && !st_push) scnt_d = scnt_q - SCNT_ONE;

    if (push_acc && !pop_acc)      count_d = count_q + CNT_ONE;
    else if (pop_acc && !push_acc) count_d = count_q - CNT_ONE;

    if (ld) begin
      if (store_ne) begin
        rd_data_d = mem_q[rd_ptr_q];
        valid_n_d = 1'b0;
      end else if (push_acc) begin
        rd_data_d = wr_data;
        valid_n_d = 1'b0;
      end else begin
        valid_n_d = 1'b1;
      end
    end

    // Flush clears occupancy but leaves rd_data and the error flags alone.
    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      scnt_d    = '0;
      count_d   = '0;
      valid_n_d = 1'b1;
    end

    // A set event in the same cycle as err_clr takes priority.
    ovf_d = (wr & wr_en & full_q & ~flush)    | (ovf_q & ~err_clr);
    unf_d = (rd & rd_en & valid_n_q & ~flush) | (unf_q & ~err_clr);
  end

  // The store needs no reset; occupancy is tracked by scnt_q and the pointers.
  always_ff @(posedge core_clk) begin
    if (st_push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      scnt_q    <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
      valid_n_q <= 1'b1;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      af_q      <= 1'b0;
      ae_q      <= 1'b1;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      scnt_q    <= scnt_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
      valid_n_q <= valid_n_d;
      full_q    <= (scnt_d == SCNT_FULL);
      empty_q   <= (count_d == '0);
      af_q      <= (count_d >= AF_THR);
      ae_q      <= (count_d <= AE_THR);
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign valid_n      = valid_n_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign count        = count_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule
`default_nettype wire

// File: tb/tb_vc_biu_sync_fifo_lvl.sv
`default_nettype none
// ============================================================================
// Module   : tb_vc_biu_sync_fifo_lvl
// Purpose  : Directed vector table against a FIFO_DEPTH=4 instance, plus a
//            scoreboarded random push/pop run against a FIFO_DEPTH=5
//            instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vc_biu_sync_fifo_lvl;

  logic        clk = 1'b0;
  logic        rst, wr_en, wr, rd_en, rd, flush, err_clr;
  logic [31:0] wr_data;

  logic [31:0] d4_data, d5_data;
  logic [2:0]  d4_cnt, d5_cnt;
  logic d4_vn, d4_full, d4_empty, d4_af, d4_ae, d4_ovf, d4_unf;
  logic d5_vn, d5_full, d5_empty, d5_af, d5_ae, d5_ovf, d5_unf;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  vc_biu_sync_fifo_lvl #(.DATA_WIDTH(32), .FIFO_DEPTH(4)) u_dut4 (
    .core_clk(clk), .core_reset(rst), .wr_en(wr_en), .wr(wr), .wr_data(wr_data),
    .rd_en(rd_en), .rd(rd), .flush(flush), .err_clr(err_clr),
    .rd_data(d4_data), .valid_n(d4_vn), .full(d4_full), .empty(d4_empty),
    .count(d4_cnt), .almost_full(d4_af), .almost_empty(d4_ae),
    .overflow(d4_ovf), .underflow(d4_unf));

  vc_biu_sync_fifo_lvl #(.DATA_WIDTH(32), .FIFO_DEPTH(5)) u_dut5 (
    .core_clk(clk), .core_reset(rst), .wr_en(wr_en), .wr(wr), .wr_data(wr_data),
    .rd_en(rd_en), .rd(rd), .flush(flush), .err_clr(err_clr),
    .rd_data(d5_data), .valid_n(d5_vn), .full(d5_full), .empty(d5_empty),
    .count(d5_cnt), .almost_full(d5_af), .almost_empty(d5_ae),
    .overflow(d5_ovf), .underflow(d5_unf));

  typedef struct {
    logic        rst, wen, wr;
    logic [31:0] wd;
    logic        ren, rd, fl, ec;
    logic [31:0] e_data;
    logic        e_vn, e_full, e_empty;
    logic [2:0]  e_cnt;
    logic        e_af, e_ae, e_ovf, e_unf;
  } vec_t;

  localparam int NV = 30;
  vec_t tbl [NV];

  function automatic vec_t mk(
      input logic r, input logic we, input logic w, input logic [31:0] d,
      input logic re, input logic rr, input logic f, input logic e,
      input logic [31:0] xd, input logic xvn, input logic xfu, input logic xem,
      input logic [2:0] xc, input logic xaf, input logic xae,
      input logic xov, input logic xun);
    vec_t v;
    v.rst = r; v.wen = we; v.wr = w; v.wd = d; v.ren = re; v.rd = rr;
    v.fl = f; v.ec = e; v.e_data = xd; v.e_vn = xvn; v.e_full = xfu;
    v.e_empty = xem; v.e_cnt = xc; v.e_af = xaf; v.e_ae = xae;
    v.e_ovf = xov; v.e_unf = xun;
    return v;
  endfunction

  task automatic drive(input logic r, input logic we, input logic w,
                       input logic [31:0] d, input logic re, input logic rr,
                       input logic f, input logic e);
    rst = r; wr_en = we; wr = w; wr_data = d;
    rd_en = re; rd = rr; flush = f; err_clr = e;
  endtask

  // Scoreboard for the depth-5 instance: all held words, head first.
  logic [31:0] mq [$];
  logic        m_valid;

  initial begin
    //                 rst we wr data          re rd fl ec | data          vn fu em cnt af ae ov un
    tbl[0]  = mk(1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,1'b0,1'b0, 32'h0,  1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b0);
    tbl[1]  = mk(1'b0,1'b1,1'b1,32'hA0, 1'b1,1'b0,1'b0,1'b0, 32'hA0, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);
    tbl[2]  = mk(1'b0,1'b1,1'b1,32'hA1, 1'b1,1'b0,1'b0,1'b0, 32'hA0, 1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b0,1'b0);
    tbl[3]  = mk(1'b0,1'b1,1'b1,32'hA2, 1'b1,1'b0,1'b0,1'b0, 32'hA0, 1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[4]  = mk(1'b0,1'b1,1'b1,32'hA3, 1'b1,1'b0,1'b0,1'b0, 32'hA0, 1'b0,1'b1,1'b0,3'd4,1'b1,1'b0,1'b0,1'b0);
    tbl[5]  = mk(1'b0,1'b1,1'b1,32'hA4, 1'b1,1'b0,1'b0,1'b0, 32'hA0, 1'b0,1'b1,1'b0,3'd4,1'b1,1'b0,1'b1,1'b0);
    tbl[6]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0, 32'hA1, 1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,1'b1,1'b0);
    tbl[7]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0, 32'hA2, 1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,1'b0);
    tbl[8]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0, 32'hA3, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b1,1'b0);
    tbl[9]  = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b1,1'b0);
    tbl[10] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b0, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b1,1'b1);
    tbl[11] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b1, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b0);
    tbl[12] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b1,1'b0,1'b1, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b1);
    tbl[13] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b1, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b0);
    tbl[14] = mk(1'b0,1'b0,1'b1,32'hBB, 1'b1,1'b0,1'b0,1'b0, 32'hA3, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b0);
    tbl[15] = mk(1'b0,1'b1,1'b1,32'h11, 1'b0,1'b0,1'b0,1'b0, 32'hA3, 1'b1,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);
    tbl[16] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);
    tbl[17] = mk(1'b0,1'b1,1'b1,32'h22, 1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b0,1'b0);
    tbl[18] = mk(1'b0,1'b1,1'b1,32'h33, 1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b0,1'b0,1'b0,3'd3,1'b1,1'b0,1'b0,1'b0);
    tbl[19] = mk(1'b0,1'b1,1'b1,32'h44, 1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b0,1'b1,1'b0,3'd4,1'b1,1'b0,1'b0,1'b0);
    tbl[20] = mk(1'b0,1'b1,1'b1,32'h55, 1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b0,1'b1,1'b0,3'd4,1'b1,1'b0,1'b1,1'b0);
    tbl[21] = mk(1'b0,1'b1,1'b1,32'h66, 1'b1,1'b1,1'b1,1'b0, 32'h11, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b1,1'b0);
    tbl[22] = mk(1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,1'b0,1'b0, 32'h11, 1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b1,1'b0);
    tbl[23] = mk(1'b0,1'b1,1'b1,32'h77, 1'b1,1'b0,1'b0,1'b0, 32'h77, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b1,1'b0);
    tbl[24] = mk(1'b0,1'b1,1'b1,32'h88, 1'b1,1'b0,1'b0,1'b0, 32'h77, 1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,1'b0);
    tbl[25] = mk(1'b0,1'b1,1'b1,32'h99, 1'b1,1'b1,1'b0,1'b0, 32'h88, 1'b0,1'b0,1'b0,3'd2,1'b0,1'b0,1'b1,1'b0);
    tbl[26] = mk(1'b1,1'b1,1'b1,32'hAA, 1'b1,1'b1,1'b0,1'b0, 32'h0,  1'b1,1'b0,1'b1,3'd0,1'b0,1'b1,1'b0,1'b0);
    // Back-to-back streaming with an empty store: each pop is refilled by bypass.
    tbl[27] = mk(1'b0,1'b1,1'b1,32'hC0, 1'b1,1'b0,1'b0,1'b0, 32'hC0, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);
    tbl[28] = mk(1'b0,1'b1,1'b1,32'hC1, 1'b1,1'b1,1'b0,1'b0, 32'hC1, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);
    tbl[29] = mk(1'b0,1'b1,1'b1,32'hC2, 1'b1,1'b1,1'b0,1'b0, 32'hC2, 1'b0,1'b0,1'b0,3'd1,1'b0,1'b1,1'b0,1'b0);

    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Directed table against the depth-4 instance
    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].wen, tbl[i].wr, tbl[i].wd,
            tbl[i].ren, tbl[i].rd, tbl[i].fl, tbl[i].ec);
      @(posedge clk);
      #1;
      vec_cnt++;
      if (d4_data !== tbl[i].e_data || d4_vn !== tbl[i].e_vn ||
          d4_full !== tbl[i].e_full || d4_empty !== tbl[i].e_empty ||
          d4_cnt !== tbl[i].e_cnt || d4_af !== tbl[i].e_af ||
          d4_ae !== tbl[i].e_ae || d4_ovf !== tbl[i].e_ovf ||
          d4_unf !== tbl[i].e_unf) begin
        err_cnt++;
        $display("FAIL vec%0d d4: got data=%h vn=%b full=%b empty=%b cnt=%0d af=%b ae=%b ovf=%b unf=%b, want data=%h vn=%b full=%b empty=%b cnt=%0d af=%b ae=%b ovf=%b unf=%b",
                 i, d4_data, d4_vn, d4_full, d4_empty, d4_cnt, d4_af, d4_ae, d4_ovf, d4_unf,
                 tbl[i].e_data, tbl[i].e_vn, tbl[i].e_full, tbl[i].e_empty, tbl[i].e_cnt,
                 tbl[i].e_af, tbl[i].e_ae, tbl[i].e_ovf, tbl[i].e_unf);
      end
    end

    // Random push/pop against the depth-5 instance (store of 4, wraps at 3)
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    mq.delete();
    m_valid = 1'b0;
    for (int c = 0; c < 50; c++) begin
      logic m_full, p_acc, q_acc;
      logic [31:0] e_head;
      int sz;
      @(negedge clk);
      drive(1'b0, 1'b1, ($urandom_range(0, 3) != 0), 32'h5000_0000 + c,
            (c % 3 == 0), $urandom_range(0, 1) == 1, 1'b0, 1'b0);
      m_full = ((mq.size() - (m_valid ? 1 : 0)) == 4);
      p_acc  = wr & wr_en & ~m_full;
      q_acc  = rd & rd_en & m_valid;
      if (q_acc) void'(mq.pop_front());
      if (p_acc) mq.push_back(wr_data);
      if (rd_en) m_valid = (mq.size() > 0);
      sz = mq.size();
      e_head = (sz > 0) ? mq[0] : 32'h0;
      @(posedge clk);
      #1;
      vec_cnt++;
      if (d5_cnt !== 3'(sz) || d5_vn !== ~m_valid ||
          (m_valid && d5_data !== e_head) ||
          d5_full !== ((sz - (m_valid ? 1 : 0)) == 4) ||
          d5_empty !== (sz == 0) || d5_af !== (sz >= 4) || d5_ae !== (sz <= 1)) begin
        err_cnt++;
        $display("FAIL rnd%0d d5: got cnt=%0d vn=%b data=%h full=%b empty=%b af=%b ae=%b, want cnt=%0d vn=%b data=%h",
                 c, d5_cnt, d5_vn, d5_data, d5_full, d5_empty, d5_af, d5_ae,
                 sz, ~m_valid, e_head);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
`default_nettype wire
